// File: rtl/softmax_max_norm_pkg.sv
// rtl/softmax_max_norm_pkg.sv - shared types, defaults and saturating subtract for the max-norm stage
//
// Purpose : mode/state enums, default geometry, flat-index width helper and a
//           width-generic saturating subtract used by the NORM datapath.
// Ports   : none (package)
package softmax_pkg;

   typedef enum logic [1:0] {
      NORM     = 2'd0,
      MAX_ONLY = 2'd1,
      BYPASS   = 2'd2,
      RSVD     = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DEF_LANES     = 4;
   localparam int DEF_ELEM_W    = 16;
   localparam int DEF_MAX_BEATS = 32;

   // Widest element the saturating subtract supports; callers sign-extend into it.
   localparam int SAT_MAX_W = 32;

   // Width of the flat element index beat*LANES+lane.
   function automatic int idx_w(input int beats, input int lanes);
      return $clog2(beats * lanes);
   endfunction

   // a - b computed one bit wider than the operands, then clamped to the
   // signed range of a w-bit element. Result is returned sign-extended.
   function automatic logic signed [SAT_MAX_W-1:0] sat_sub(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int                          w
   );
      logic signed [SAT_MAX_W:0] d;
      logic signed [SAT_MAX_W:0] hi;
      logic signed [SAT_MAX_W:0] lo;
      d  = {a[SAT_MAX_W-1], a} - {b[SAT_MAX_W-1], b};
      hi = ((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1);
      lo = ~hi;
      if (d > hi) begin
         return hi[SAT_MAX_W-1:0];
      end else if (d < lo) begin
         return lo[SAT_MAX_W-1:0];
      end else begin
         return d[SAT_MAX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/softmax_max_norm_if.sv
// rtl/softmax_max_norm_if.sv - input/output beat streams of the max-norm stage
//
// Purpose : bundles the input beat stream and the output beat stream.
// Signals : in_valid_i/in_ready_o/in_data_i    input beat handshake
//           out_valid_o/out_ready_i/out_data_o/out_last_o  output beat handshake
// Modports: slave  - the max-norm stage
//           master - the environment feeding and draining it
interface softmax_max_norm_if #(
   parameter int DATA_W = 64
) ();
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic              out_last_o;

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_last_o
   );

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/softmax_max_norm_lane_argmax_tree.sv
// rtl/softmax_max_norm_lane_argmax_tree.sv - combinational per-beat running max/argmax update
//
// Purpose : folds one beat of LANES signed elements into the running max/index.
// Ports   : i_data  beat data, lane k in [k*ELEM_W +: ELEM_W]
//           i_beat  beat number of i_data within the row
//           i_max/i_idx  incoming running max and its flat index
//           o_max/o_idx  updated running max and flat index
module lane_argmax_tree
   import softmax_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int ELEM_W    = DEF_ELEM_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int IDX_W     = idx_w(MAX_BEATS, LANES),
   parameter int BEAT_W    = $clog2(MAX_BEATS)
) (
   input  logic        [LANES*ELEM_W-1:0] i_data,
   input  logic        [BEAT_W-1:0]       i_beat,
   input  logic signed [ELEM_W-1:0]       i_max,
   input  logic        [IDX_W-1:0]        i_idx,
   output logic signed [ELEM_W-1:0]       o_max,
   output logic        [IDX_W-1:0]        o_idx
);

   // Lanes are scanned in increasing index order and only a strictly greater
   // value replaces the current best, so the lowest flat index wins ties.
   always_comb begin
      o_max = i_max;
      o_idx = i_idx;
      for (int k = 0; k < LANES; k++) begin
         if ($signed(i_data[k*ELEM_W +: ELEM_W]) > o_max) begin
            o_max = i_data[k*ELEM_W +: ELEM_W];
            o_idx = IDX_W'(i_beat) * IDX_W'(LANES) + IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/softmax_max_norm.sv
// rtl/softmax_max_norm.sv - buffered row max-seek and x-max replay for quantised softmax
//
// Purpose : loads one row into a local buffer while tracking max/argmax, then
//           replays it as sat(x - max) (NORM), unmodified (BYPASS) or not at
//           all (MAX_ONLY / reserved).
// Ports   : clk_i, rst_i (sync, active-high)
//           start_i, cfg_beats_i, cfg_mode_i  row start and config, latched in IDLE
//           busy_o (LOAD/EMIT), done_o (one-cycle pulse)
//           bus   input and output beat streams (slave side)
//           max_o, max_idx_o  row maximum and its flat index
module softmax_max_norm
   import softmax_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int ELEM_W    = DEF_ELEM_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int DATA_W    = LANES * ELEM_W
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [$clog2(MAX_BEATS):0]          cfg_beats_i,
   input  logic [1:0]                          cfg_mode_i,
   output logic                                busy_o,
   output logic                                done_o,
   softmax_max_norm_if.slave                   bus,
   output logic signed [ELEM_W-1:0]            max_o,
   output logic [idx_w(MAX_BEATS, LANES)-1:0]  max_idx_o
);

   localparam int                BEAT_W    = $clog2(MAX_BEATS);
   localparam int                IDX_W     = idx_w(MAX_BEATS, LANES);
   localparam logic [ELEM_W-1:0] MOST_NEG  = {1'b1, {(ELEM_W-1){1'b0}}};
   localparam logic [BEAT_W:0]   BEATS_MAX = (BEAT_W+1)'(MAX_BEATS);
   localparam logic [BEAT_W:0]   ONE       = (BEAT_W+1)'(1);

   state_e                     r_state;
   state_e                     w_next;
   mode_e                      r_mode;
   logic [BEAT_W:0]            r_beats;
   logic [BEAT_W:0]            r_wr_cnt;
   logic [BEAT_W:0]            r_rd_cnt;
   logic [DATA_W-1:0]          r_buf [MAX_BEATS];
   logic signed [ELEM_W-1:0]   r_max;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_out_valid;
   logic                       r_out_last;
   logic [DATA_W-1:0]          r_out_data;

   logic                       w_in_fire;
   logic                       w_in_last;
   logic                       w_out_fire;
   logic                       w_out_load;
   logic                       w_start;
   logic [BEAT_W:0]            w_cfg_beats;
   logic [DATA_W-1:0]          w_rd_data;
   logic [DATA_W-1:0]          w_norm_data;
   logic signed [ELEM_W-1:0]   w_tree_max;
   logic [IDX_W-1:0]           w_tree_idx;
   logic                       w_in_ready;
   logic                       w_busy;
   logic                       w_done;

   assign w_start     = (r_state == IDLE) && start_i;
   assign w_cfg_beats = (cfg_beats_i > BEATS_MAX) ? BEATS_MAX : cfg_beats_i;
   assign w_in_fire   = (r_state == LOAD) && bus.in_valid_i;
   assign w_in_last   = w_in_fire && ((r_wr_cnt + ONE) == r_beats);
   assign w_out_fire  = r_out_valid && bus.out_ready_i;
   // Refill the output register whenever it is empty or being drained,
   // as long as buffered beats remain.
   assign w_out_load  = (r_state == EMIT) && (r_rd_cnt != r_beats) &&
                        (!r_out_valid || bus.out_ready_i);
   assign w_rd_data   = r_buf[r_rd_cnt[BEAT_W-1:0]];

   lane_argmax_tree #(
      .LANES     (LANES),
      .ELEM_W    (ELEM_W),
      .MAX_BEATS (MAX_BEATS),
      .IDX_W     (IDX_W),
      .BEAT_W    (BEAT_W)
   ) u_argmax (
      .i_data (bus.in_data_i),
      .i_beat (r_wr_cnt[BEAT_W-1:0]),
      .i_max  (r_max),
      .i_idx  (r_idx),
      .o_max  (w_tree_max),
      .o_idx  (w_tree_idx)
   );

   always_comb begin
      w_norm_data = '0;
      for (int k = 0; k < LANES; k++) begin
         w_norm_data[k*ELEM_W +: ELEM_W] = ELEM_W'(sat_sub(
            {{(SAT_MAX_W-ELEM_W){w_rd_data[k*ELEM_W+ELEM_W-1]}}, w_rd_data[k*ELEM_W +: ELEM_W]},
            {{(SAT_MAX_W-ELEM_W){r_max[ELEM_W-1]}}, r_max},
            ELEM_W));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_next = (w_cfg_beats == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            if (w_in_last) begin
               w_next = (r_mode == NORM || r_mode == BYPASS) ? EMIT : DONE;
            end
         end
         EMIT: begin
            w_busy = 1'b1;
            if (w_out_fire && r_out_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mode      <= NORM;
         r_beats     <= '0;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
         r_max       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_start) begin
            r_beats  <= w_cfg_beats;
            r_mode   <= mode_e'(cfg_mode_i);
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_max    <= MOST_NEG;
            r_idx    <= '0;
         end
         if (w_in_fire) begin
            r_wr_cnt <= r_wr_cnt + ONE;
            r_max    <= w_tree_max;
            r_idx    <= w_tree_idx;
         end
         if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= (r_mode == NORM) ? w_norm_data : w_rd_data;
            r_out_last  <= ((r_rd_cnt + ONE) == r_beats);
            r_rd_cnt    <= r_rd_cnt + ONE;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   // Row buffer carries no reset; it is always fully rewritten before replay.
   always_ff @(posedge clk_i) begin
      if (w_in_fire) begin
         r_buf[r_wr_cnt[BEAT_W-1:0]] <= bus.in_data_i;
      end
   end

   assign bus.in_ready_o  = w_in_ready;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_data_o  = r_out_data;
   assign bus.out_last_o  = r_out_last;
   assign busy_o          = w_busy;
   assign done_o          = w_done;
   assign max_o           = r_max;
   assign max_idx_o       = r_idx;

endmodule

// File: tb/tb_softmax_max_norm.sv
// tb/tb_softmax_max_norm.sv - scoreboard bench for softmax_max_norm
module tb_softmax_max_norm;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic [5:0]  cfg_beats;
   logic [1:0]  cfg_mode;
   logic        busy;
   logic        done;
   logic [15:0] max_v;
   logic [6:0]  max_idx;

   softmax_max_norm_if #(.DATA_W(64)) bus ();

   softmax_max_norm #(
      .LANES     (4),
      .ELEM_W    (16),
      .MAX_BEATS (32)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .cfg_beats_i (cfg_beats),
      .cfg_mode_i  (cfg_mode),
      .busy_o      (busy),
      .done_o      (done),
      .bus         (bus),
      .max_o       (max_v),
      .max_idx_o   (max_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] rows [64];
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic l);
      exp_t e;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Output monitor: every output handshake pops one expected beat; a stalled
   // beat must hold data/last/valid until it is taken.
   always @(negedge clk) begin
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            if (!(bus.out_valid_o && bus.out_data_o == prev_data && bus.out_last_o == prev_last)) begin
               n_errors++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                        bus.out_valid_o, bus.out_data_o, bus.out_last_o, prev_data, prev_last);
            end
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_beat: got d=%h l=%b expected no beat",
                        bus.out_data_o, bus.out_last_o);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (bus.out_data_o !== e.data || bus.out_last_o !== e.last) begin
                  n_errors++;
                  $display("FAIL out_beat: got d=%h l=%b expected d=%h l=%b",
                           bus.out_data_o, bus.out_last_o, e.data, e.last);
               end
            end
         end
         prev_stall = bus.out_valid_o && !bus.out_ready_i;
         prev_data  = bus.out_data_o;
         prev_last  = bus.out_last_o;
      end
   end

   task automatic start_row(input int beats, input int mode);
      @(posedge clk); #1;
      start_i   = 1'b1;
      cfg_beats = 6'(beats);
      cfg_mode  = 2'(mode);
      @(posedge clk); #1;
      start_i   = 1'b0;
   endtask

   // Returns #1 after the edge that accepted the last beat.
   task automatic feed(input int n, output int acc);
      acc = 0;
      for (int c = 0; c < n + 20 && acc < n; c++) begin
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = rows[acc];
         @(negedge clk);
         if (bus.in_ready_o) acc++;
         @(posedge clk); #1;
      end
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [15:0] emax, input logic [6:0] eidx);
      bit found;
      found = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) begin
            found = 1;
            break;
         end
      end
      check({tag, "_done_seen"}, 64'(found), 64'(1));
      if (found) begin
         check({tag, "_max"}, 64'(max_v), 64'(emax));
         check({tag, "_idx"}, 64'(max_idx), 64'(eidx));
         check({tag, "_busy_in_done"}, 64'(busy), 64'(0));
         check({tag, "_all_beats_out"}, 64'(exp_q.size()), 64'(0));
         @(negedge clk);
         check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acc;
      bit found;
      bit seen;
      logic [15:0] m_at_done;
      logic [6:0]  i_at_done;

      rst_i           = 1'b1;
      start_i         = 1'b0;
      cfg_beats       = '0;
      cfg_mode        = '0;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.out_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready_o), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
      check("rst_out_data", bus.out_data_o, 64'(0));
      check("rst_out_last", 64'(bus.out_last_o), 64'(0));
      check("rst_max", 64'(max_v), 64'(0));
      check("rst_idx", 64'(max_idx), 64'(0));

      // 1: NORM, two beats
      rows[0] = pk(1, 5, 3, 2);
      rows[1] = pk(4, 5, 0, -1);
      push(pk(-4, 0, -2, -3), 1'b0);
      push(pk(-1, 0, -5, -6), 1'b1);
      bus.out_ready_i = 1'b1;
      start_row(2, 0);
      check("t1_busy_load", 64'(busy), 64'(1));
      feed(2, acc);
      check("t1_accepted", 64'(acc), 64'(2));
      check("t1_in_ready_drop", 64'(bus.in_ready_o), 64'(0));
      check("t1_no_valid_t1", 64'(bus.out_valid_o), 64'(0));
      @(posedge clk); #1;
      check("t1_valid_t2", 64'(bus.out_valid_o), 64'(1));
      wait_done("t1", 16'd5, 7'd1);

      // 2: NORM saturation
      rows[0] = pk(-32768, 32767, 0, 0);
      push(pk(-32768, 0, -32767, -32767), 1'b1);
      start_row(1, 0);
      feed(1, acc);
      wait_done("t2", 16'h7FFF, 7'd1);

      // 3: BYPASS with backpressure
      rows[0] = pk(10, -3, 7, 7);
      rows[1] = pk(11, 11, 0, 0);
      rows[2] = pk(-1, -2, -3, -4);
      rows[3] = pk(5, 11, 2, 9);
      for (int b = 0; b < 4; b++) push(rows[b], 1'(b == 3));
      bus.out_ready_i = 1'b0;
      start_row(4, 2);
      feed(4, acc);
      check("t3_accepted", 64'(acc), 64'(4));
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.out_valid_o) begin
            found = 1;
            break;
         end
      end
      check("t3_valid_seen", 64'(found), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
         bus.out_ready_i = !bus.out_ready_i;
      end
      check("t3_done_seen", 64'(found), 64'(1));
      check("t3_max", 64'(max_v), 64'(16'd11));
      check("t3_idx", 64'(max_idx), 64'(4));
      check("t3_all_beats_out", 64'(exp_q.size()), 64'(0));
      bus.out_ready_i = 1'b1;

      // 4: MAX_ONLY, full 32-beat row of -7
      for (int b = 0; b < 32; b++) rows[b] = pk(-7, -7, -7, -7);
      start_row(32, 1);
      feed(32, acc);
      check("t4_accepted", 64'(acc), 64'(32));
      check("t4_done_t1", 64'(done), 64'(1));
      wait_done("t4", 16'hFFF9, 7'd0);

      // 5: reset in the middle of EMIT
      rows[0] = pk(1, 2, 3, 4);
      rows[1] = pk(5, 6, 7, 8);
      rows[2] = pk(0, 0, 0, 0);
      push(pk(-7, -6, -5, -4), 1'b0);
      start_row(3, 0);
      feed(3, acc);
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.out_valid_o && bus.out_ready_i) begin
            found = 1;
            break;
         end
      end
      check("t5_first_beat", 64'(found), 64'(1));
      @(posedge clk); #1;
      rst_i           = 1'b1;
      bus.out_ready_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b0;
      check("t5_valid_cleared", 64'(bus.out_valid_o), 64'(0));
      check("t5_busy_cleared", 64'(busy), 64'(0));
      check("t5_in_ready_cleared", 64'(bus.in_ready_o), 64'(0));
      check("t5_max_cleared", 64'(max_v), 64'(0));
      bus.out_ready_i = 1'b1;
      seen = 0;
      if (done) seen = 1;
      repeat (4) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("t5_no_done", 64'(seen), 64'(0));
      check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
      rows[0] = pk(2, 2, 9, 2);
      push(pk(-7, -7, 0, -7), 1'b1);
      start_row(1, 0);
      feed(1, acc);
      wait_done("t5b", 16'd9, 7'd2);

      // 6: zero-length row, then an over-long row clamped to 32 beats
      start_row(0, 2);
      check("t6_done_now", 64'(done), 64'(1));
      check("t6_max_neg", 64'(max_v), 64'(16'h8000));
      check("t6_idx_zero", 64'(max_idx), 64'(0));
      check("t6_no_in_ready", 64'(bus.in_ready_o), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      check("t6_done_one_cycle", 64'(done), 64'(0));

      for (int b = 0; b < 64; b++) rows[b] = pk(b, b, b, b);
      start_row(40, 1);
      acc       = 0;
      seen      = 0;
      m_at_done = '0;
      i_at_done = '0;
      for (int c = 0; c < 40; c++) begin
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = rows[acc];
         @(negedge clk);
         if (bus.in_ready_o) acc++;
         if (done) begin
            seen      = 1;
            m_at_done = max_v;
            i_at_done = max_idx;
         end
         @(posedge clk); #1;
      end
      bus.in_valid_i = 1'b0;
      check("t6_clamped_beats", 64'(acc), 64'(32));
      check("t6_clamp_done", 64'(seen), 64'(1));
      check("t6_clamp_max", 64'(m_at_done), 64'(16'd31));
      check("t6_clamp_idx", 64'(i_at_done), 64'(124));

      repeat (3) @(posedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/softmax_max_norm.md
Name: softmax_max_norm

Overview:
Parametrised successor to the softmax engine's max-seek stage for quantised (signed fixed-point) softmax. It accepts one row of up to MAX_BEATS beats of LANES elements and stores the row in an internal buffer, so upstream sends it only once. It tracks the row maximum and its flat index, then replays the row as x - max with saturation. Unlike the previous stage it has full out_valid/out_ready backpressure, a runtime row length, three modes and an argmax output. It sits between the stream reader and the exp/sum datapath.

Parameters:
LANES, 4, elements per beat
ELEM_W, 16, signed element width in bits
MAX_BEATS, 32, row buffer depth in beats (power of two)
DATA_W, LANES*ELEM_W, stream data width (derived; do not override)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse; accepted only in IDLE
cfg_beats_i  in  $clog2(MAX_BEATS)+1  row length in beats, latched at start
cfg_mode_i  in  2  0 NORM, 1 MAX_ONLY, 2 BYPASS, 3 reserved (treated as MAX_ONLY); latched at start
busy_o  out  1  high in LOAD and EMIT
done_o  out  1  one-cycle pulse in DONE
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input ready
in_data_i  in  DATA_W  input beat; lane k in bits [k*ELEM_W +: ELEM_W]
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream ready
out_data_o  out  DATA_W  output beat
out_last_o  out  1  high with the final output beat
max_o  out  ELEM_W  row maximum; valid from DONE until the next start
max_idx_o  out  $clog2(MAX_BEATS*LANES)  flat index of the maximum, computed as beat*LANES+lane

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst_i is sampled on the rising edge of clk_i.
- Reset values: state IDLE; all outputs 0, including max_o and max_idx_o. Buffer contents are not reset.
- Reset during any state aborts the operation. The next cycle is IDLE with all outputs 0, and no done_o pulse is issued.
- FSM states: IDLE, LOAD, EMIT, DONE.
  - IDLE -> LOAD on start_i when beats >= 1.
  - IDLE -> DONE on start_i when beats == 0. max_o is then the most negative value and max_idx_o is 0.
  - cfg_beats_i > MAX_BEATS is clamped to MAX_BEATS.
- LOAD:
  - in_ready_o=1 in LOAD only.
  - Each handshake writes buffer[wr_ptr] and updates the running max.
  - Tie rule: an element replaces the running max only if it is strictly greater, so the lowest flat index wins ties.
  - The running max starts at the most negative value with index 0.
  - When the last input beat is accepted at cycle t: in_ready_o drops at t+1. The next state is EMIT for NORM/BYPASS, or DONE for MAX_ONLY.
- EMIT:
  - Output is registered. First out_valid_o rises at t+2.
  - The output register loads when !out_valid_o || out_ready_i. This gives 1 beat/cycle under constant ready.
  - While out_valid_o && !out_ready_i, out_data_o and out_last_o hold stable.
  - NORM: each lane outputs sat(x - max), where the subtraction is done in ELEM_W+1 bits and saturated to the ELEM_W signed range. Results are always <= 0.
  - BYPASS: lanes are output unmodified.
  - After the out_last_o handshake, the next state is DONE.
- DONE: lasts one cycle. done_o=1, busy_o=0, max_o and max_idx_o are final. Then the FSM returns to IDLE.
- start_i outside IDLE is ignored. Config inputs are ignored except at an accepted start.
- in_valid_i outside LOAD is ignored; no beat is consumed.

Decomposition:
- Package softmax_pkg holds:
  - mode_e enum (NORM, MAX_ONLY, BYPASS, RSVD)
  - state_e enum
  - function sat_sub(a, b): signed, ELEM_W-generic via parameter
  - localparams for the index width
- Sub-module lane_argmax_tree is purely combinational. Given one beat plus the incoming running max/index, it returns the updated max/index. It applies the lowest-index tie rule and is instantiated once.

Test Plan (LANES=4, ELEM_W=16):
1. NORM, beats=2, rows [1,5,3,2] then [4,5,0,-1], out_ready=1 -> max 5, idx 1; outputs [-4,0,-2,-3] then [-1,0,-5,-6]; out_last_o on the 2nd beat; first out_valid_o at t+2; done_o pulse after the last handshake.
2. NORM saturation, beats=1, row [-32768,32767,0,0] -> output [-32768,0,-32767,-32767]; max 32767, idx 1.
3. Backpressure, beats=4 BYPASS: hold out_ready low 3 cycles while beat 0 is valid, then toggle every cycle -> data stable while stalled; all 4 beats appear in order with no drops or duplicates; out_last_o only on beat 3.
4. MAX_ONLY, beats=32, all elements -7 -> out_valid_o never rises; max -7, idx 0; done_o at t+1.
5. Reset mid-EMIT: assert rst_i after 1 of 3 NORM beats -> next cycle out_valid_o=0, busy_o=0, in_ready_o=0, no done_o. A following start with beats=1, row [2,2,9,2] yields [-7,-7,0,-7], max 9, idx 2.
6. beats=0 start -> done_o 1 cycle after start, max_o=-32768, max_idx_o=0, no in_ready_o and no out_valid_o. Also beats=40 -> clamped to 32 accepted beats.
